cmd_receiver: RTL and testbench

- Robot-side receiving end of the two-byte remote command link.
- The host sends a 16-bit command as two 8N1 UART bytes, high byte first, then low byte. This block deserialises those bytes from RX and reassembles the 16-bit word.
- It presents the word to the command processor with a cmd_rdy/clr_cmd_rdy handshake.
- It owns both bit-level reception and byte-pair framing.

---
 rtl/cmd_link_pkg.sv | 29 ++
 rtl/cmd_receiver_uart_rx.sv | 97 +++++++++
 rtl/cmd_receiver.sv | 102 ++++++++++
 tb/tb_cmd_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_link_pkg.sv
// Shared types and constants for the two-byte remote command link.
// Used by the robot-side receiver and the host-side sender.
package cmd_link_pkg;

  localparam int CMD_W = 16;
  localparam int BYTE_W = 8;
  localparam int DEF_BAUD_DIV = 2604;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

  typedef enum logic {
    IDLE,
    WAIT_LOW
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Baud counter width: never narrower than 12 bits.
  function automatic int baud_cnt_w(input int div);
    int w;
    w = $clog2(div + 1);
    return (w < 12) ? 12 : w;
  endfunction

endpackage

// File: rtl/cmd_receiver_uart_rx.sv
// 8N1 UART byte receiver with two-flop RX synchroniser.
// Pulses byte_vld for one cycle at the stop-bit sample.
module uart_rx_byte
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_data,
  output logic              stop_err
);

  localparam int CW = baud_cnt_w(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic              start_edge;
  logic              full_tick;
  rx_state_t         state;
  logic [CW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] data_sr;

  assign start_edge = rx_prev & ~rx_sync;
  assign full_tick  = (baud_cnt == FULL_M1);

  // Two-flop synchroniser plus one history flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit-level receive FSM: start check at half bit, then full-bit samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_sr  <= '0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (start_edge) state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd1;
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (full_tick) begin
            baud_cnt <= '0;
            data_sr  <= {rx_sync, data_sr[BYTE_W-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd8) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (full_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign byte_vld  = (state == RX_STOP) && full_tick;
  assign byte_data = data_sr;
  assign stop_err  = byte_vld & ~rx_sync;

endmodule

// File: rtl/cmd_receiver.sv
// Two-byte command receiver: UART bytes reassembled into a 16-bit cmd.
// Optional WAIT_LOW timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_receiver
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV    = DEF_BAUD_DIV,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX,
  input  logic             clr_cmd_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic             frame_err
);

  logic              byte_vld;
  logic [BYTE_W-1:0] byte_data;
  logic              stop_err;
  logic              good_byte;
  logic              bad_byte;
  logic              tmo_hit;
  frame_state_t      state;
  logic [BYTE_W-1:0] hi_byte;

  uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .stop_err (stop_err)
  );

  assign good_byte = byte_vld & ~stop_err;
  assign bad_byte  = byte_vld & stop_err;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == WAIT_LOW) && (tmo_cnt == TMO_M1);

  // Cycles spent in WAIT_LOW; held at zero while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // Timer absent: WAIT_LOW waits for the low byte forever.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // Byte-pair framing, output registers and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_byte   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bad_byte) begin
            frame_err <= 1'b1;
          end else if (good_byte) begin
            hi_byte <= byte_data;
            cmd_rdy <= 1'b0;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (bad_byte) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (good_byte) begin
            cmd       <= {hi_byte, byte_data};
            cmd_rdy   <= 1'b1;
            frame_err <= 1'b0;
            state     <= IDLE;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_receiver.sv
// Directed bench for cmd_receiver with a byte-event reference model.
// Honours CMD_TIMEOUT_EN the same way as the design.
module tb_cmd_receiver;

  localparam int B   = 16;
  localparam int TMO = 400;
  // Edges from the edge before the start bit to the stop-bit sample:
  // 2 synchroniser flops + 1 transition compare, half bit, 9 full bits.
  localparam int LAT = 3 + B / 2 + 9 * B;
`ifdef CMD_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;

  always #5 clk = ~clk;

  cmd_receiver #(
    .BAUD_DIV   (B),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frame_err  (frame_err)
  );

  typedef struct {
    int       at;
    bit [7:0] b;
    bit       ok;
  } ev_t;

  ev_t      evq[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       clr_at = -1;
  bit       checking = 1'b0;
  bit [15:0] m_cmd;
  bit       m_rdy;
  bit       m_ferr;
  bit       m_wait;
  bit [7:0] m_hi;
  int       m_hcyc;

  // Reference: whole bytes arrive at precomputed edges, paired by rule.
  always @(posedge clk) begin
    ev_t e;
    bit  got;
    bit  set;
    cyc++;
    got = 1'b0;
    set = 1'b0;
    if (rst) begin
      m_cmd  = '0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_wait = 1'b0;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e   = evq.pop_front();
        got = 1'b1;
      end
      if (got && !e.ok) begin
        m_ferr = 1'b1;
        m_wait = 1'b0;
      end else if (got && m_wait && (!TMO_ON || cyc - m_hcyc <= TMO)) begin
        m_cmd  = {m_hi, e.b};
        m_rdy  = 1'b1;
        m_ferr = 1'b0;
        m_wait = 1'b0;
        set    = 1'b1;
      end else if (got) begin
        m_hi   = e.b;
        m_rdy  = 1'b0;
        m_wait = 1'b1;
        m_hcyc = cyc;
      end else if (m_wait && TMO_ON && cyc - m_hcyc >= TMO) begin
        m_wait = 1'b0;
      end
      if (clr_cmd_rdy && !set) m_rdy = 1'b0;
    end
  end

  // Drive clr_cmd_rdy so it is sampled on edge number clr_at.
  always @(posedge clk) begin
    #1;
    clr_cmd_rdy = (cyc == clr_at - 1);
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (checking) begin
      total++;
      if (cmd !== m_cmd || cmd_rdy !== m_rdy || frame_err !== m_ferr) begin
        bad++;
        $display("FAIL model_cmp cyc=%0d got cmd=%h rdy=%b ferr=%b want cmd=%h rdy=%b ferr=%b",
                 cyc, cmd, cmd_rdy, frame_err, m_cmd, m_rdy, m_ferr);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input bit [7:0] b, input bit stop,
                           input bit clr_on_stop);
    ev_t e;
    @(posedge clk);
    #1;
    RX   = 1'b0;
    e.at = cyc + LAT;
    e.b  = b;
    e.ok = stop;
    evq.push_back(e);
    if (clr_on_stop) clr_at = e.at;
    for (int j = 1; j <= 9; j++) begin
      repeat (B) @(posedge clk);
      #1;
      RX = (j <= 8) ? b[j-1] : stop;
    end
    repeat (B) @(posedge clk);
    #1;
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #2;
    clr_at = cyc + 2;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("reset_ferr", {15'd0, frame_err}, 16'd0);

    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    chk("pair_cmd", cmd, 16'hA53C);
    chk("pair_rdy", {15'd0, cmd_rdy}, 16'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pair_rdy_hold", {15'd0, cmd_rdy}, 16'd1);
    pulse_clr();
    @(negedge clk);
    chk("pair_rdy_clr", {15'd0, cmd_rdy}, 16'd0);
    pulse_clr();

    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b1);
    @(negedge clk);
    chk("coll_cmd", cmd, 16'h1234);
    chk("coll_rdy", {15'd0, cmd_rdy}, 16'd1);

    send_byte(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    chk("bad_ferr", {15'd0, frame_err}, 16'd1);
    chk("bad_cmd_kept", cmd, 16'h1234);
    send_byte(8'h80, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    chk("recov_cmd", cmd, 16'h8001);
    chk("recov_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("recov_ferr", {15'd0, frame_err}, 16'd0);

    send_byte(8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_pair_cmd", cmd, 16'h0203);

    send_byte(8'hAA, 1'b1, 1'b0);
    repeat (500) @(posedge clk);
    send_byte(8'h55, 1'b1, 1'b0);
    @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    chk("tmo_mid_cmd", cmd, 16'h0203);
    chk("tmo_mid_rdy", {15'd0, cmd_rdy}, 16'd0);
`else
    chk("tmo_mid_cmd", cmd, 16'hAA55);
    chk("tmo_mid_rdy", {15'd0, cmd_rdy}, 16'd1);
`endif
    send_byte(8'h66, 1'b1, 1'b0);
    @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    chk("tmo_end_cmd", cmd, 16'h5566);
    chk("tmo_end_rdy", {15'd0, cmd_rdy}, 16'd1);
`else
    chk("tmo_end_cmd", cmd, 16'hAA55);
    chk("tmo_end_rdy", {15'd0, cmd_rdy}, 16'd0);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
